// File: rtl/alu_sequencer.sv
// alu_sequencer: control end of a Hack ALU. Fetches 16-bit Hack instructions,
// holds the A/D/PC registers, sends operands and an op code to the ALU, and
// writes the results back to A, D or data memory. Jumps are resolved from the
// zr/ng flags captured alongside the result.
module alu_sequencer #(
    parameter int              PC_W     = 15,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            instr_req,
    output logic [PC_W-1:0] instr_addr,
    input  logic            instr_valid,
    input  logic [15:0]     instr,
    output logic [PC_W-1:0] mem_addr,
    input  logic [15:0]     mem_rdata,
    output logic [15:0]     mem_wdata,
    output logic            mem_we,
    output logic [15:0]     alu_x,
    output logic [15:0]     alu_y,
    output logic [5:0]      alu_op,
    input  logic [15:0]     alu_out,
    input  logic            alu_zr,
    input  logic            alu_ng
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        WB    = 2'd2
    } state_t;

    // ALU op for the constant 0; keeps the ALU quiet when no C-instruction runs
    localparam logic [5:0] OP_ZERO = 6'b101010;

    state_t          state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [15:0]     a_reg;
    logic [15:0]     d_reg;
    logic [15:0]     ir_reg;
    logic [15:0]     res_reg;
    logic            zr_reg;
    logic            ng_reg;
    logic            req_reg;
    logic            we_reg;

    logic [PC_W-1:0] pc_inc;
    logic            c_exec;
    logic            jmp;

    assign pc_inc     = pc_reg + {{(PC_W-1){1'b0}}, 1'b1};
    assign c_exec     = (state_reg == EXEC) && ir_reg[15];
    assign jmp        = (ir_reg[2] & ng_reg) | (ir_reg[1] & zr_reg) |
                        (ir_reg[0] & ~zr_reg & ~ng_reg);

    assign instr_req  = req_reg;
    assign instr_addr = pc_reg;
    // Data address always follows A, so during WB it is still the pre-update A
    assign mem_addr   = a_reg[PC_W-1:0];
    assign mem_wdata  = res_reg;
    assign mem_we     = we_reg;

    // ALU operands only carry real values while a C-instruction is executing
    always_comb begin
        alu_op = OP_ZERO;
        alu_x  = 16'h0000;
        alu_y  = 16'h0000;
        if (c_exec) begin
            alu_op = ir_reg[11:6];
            alu_x  = d_reg;
            alu_y  = ir_reg[12] ? mem_rdata : a_reg;
        end
    end

    // Sequencer FSM: fetch, execute, optional write-back; all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_PC;
            a_reg     <= 16'h0000;
            d_reg     <= 16'h0000;
            ir_reg    <= 16'h0000;
            res_reg   <= 16'h0000;
            zr_reg    <= 1'b0;
            ng_reg    <= 1'b0;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
        end else begin
            case (state_reg)
                FETCH: begin
                    // A fetch is only accepted against an outstanding request
                    if (req_reg && instr_valid) begin
                        ir_reg    <= instr;
                        req_reg   <= 1'b0;
                        state_reg <= EXEC;
                    end else begin
                        req_reg   <= 1'b1;
                    end
                end
                EXEC: begin
                    if (!ir_reg[15]) begin
                        a_reg     <= {1'b0, ir_reg[14:0]};
                        pc_reg    <= pc_inc;
                        req_reg   <= 1'b1;
                        state_reg <= FETCH;
                    end else begin
                        res_reg   <= alu_out;
                        zr_reg    <= alu_zr;
                        ng_reg    <= alu_ng;
                        we_reg    <= ir_reg[3];
                        state_reg <= WB;
                    end
                end
                WB: begin
                    if (ir_reg[5]) a_reg <= res_reg;
                    if (ir_reg[4]) d_reg <= res_reg;
                    // Jump target is the A value from before this write-back
                    pc_reg    <= jmp ? a_reg[PC_W-1:0] : pc_inc;
                    we_reg    <= 1'b0;
                    req_reg   <= 1'b1;
                    state_reg <= FETCH;
                end
                default: begin
                    we_reg    <= 1'b0;
                    req_reg   <= 1'b0;
                    state_reg <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer with directed and random Hack
// programs. A Hack ALU and data memory sit beside the DUT; a mnemonic-level
// Hack CPU model predicts PC, A, D and memory writes for every instruction.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_req;
    logic [14:0] instr_addr;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic [14:0] mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_op;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;

    int n_cmp = 0;
    int n_err = 0;

    // Data memory seen by the DUT, and the model's own copy
    logic [15:0] phys_mem [0:32767];
    logic [15:0] ref_mem  [0:32767];

    // Model architectural state
    logic [14:0] m_pc;
    logic [15:0] m_a;
    logic [15:0] m_d;

    logic [5:0] comp_tab [18] = '{
        6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
        6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
        6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101
    };

    alu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr       (instr),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .alu_zr      (alu_zr),
        .alu_ng      (alu_ng)
    );

    always #5 clk = ~clk;

    // Hack ALU built from its control bits
    always_comb begin
        logic [15:0] x1, y1, o;
        x1 = alu_op[5] ? 16'h0000 : alu_x;
        x1 = alu_op[4] ? ~x1 : x1;
        y1 = alu_op[3] ? 16'h0000 : alu_y;
        y1 = alu_op[2] ? ~y1 : y1;
        o  = alu_op[1] ? (x1 + y1) : (x1 & y1);
        alu_out = alu_op[0] ? ~o : o;
        alu_zr  = (alu_out == 16'h0000);
        alu_ng  = alu_out[15];
    end

    assign mem_rdata = phys_mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) phys_mem[mem_addr] <= mem_wdata;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hack comp mnemonics evaluated directly (y is A or M)
    function automatic logic [15:0] ref_comp(input logic [5:0] c, input logic [15:0] d,
                                             input logic [15:0] y);
        case (c)
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return d;
            6'b110000: return y;
            6'b001101: return ~d;
            6'b110001: return ~y;
            6'b001111: return -d;
            6'b110011: return -y;
            6'b011111: return d + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return d - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return d + y;
            6'b010011: return d - y;
            6'b000111: return y - d;
            6'b000000: return d & y;
            6'b010101: return d | y;
            default:   return 16'hxxxx;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", instr_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_wdata", mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_pc = 15'd0;
        m_a = 16'd0;
        m_d = 16'd0;
        check("rel_req", instr_req, 1);
        check("rel_addr", instr_addr, 0);
        check("rel_we", mem_we, 0);
        check("rel_a", dut.a_reg, 0);
        check("rel_d", dut.d_reg, 0);
        $display("reset released: pc=0x%04h", instr_addr);
    endtask

    // Runs one instruction; called at 1 time unit after a rising edge in FETCH
    task automatic run_instr(input logic [15:0] ins, input int stall);
        logic [15:0] y, res, a_old;
        logic [14:0] pc_next;
        logic        jmp;
        check("fetch_req", instr_req, 1);
        check("fetch_addr", instr_addr, m_pc);
        check("idle_op", alu_op, 6'b101010);
        for (int i = 0; i < stall; i++) begin
            instr_valid = 1'b0;
            instr = 16'($urandom);
            @(posedge clk);
            #1;
            check("stall_req", instr_req, 1);
            check("stall_addr", instr_addr, m_pc);
        end
        instr_valid = 1'b1;
        instr = ins;
        @(posedge clk);
        #1;
        // Junk on the fetch port outside FETCH must be ignored
        instr_valid = 1'($urandom_range(0, 1));
        instr = 16'($urandom);
        check("exec_req", instr_req, 0);
        pc_next = m_pc + 15'd1;
        if (!ins[15]) begin
            m_a = {1'b0, ins[14:0]};
            m_pc = pc_next;
            @(posedge clk);
            #1;
            instr_valid = 1'b0;
        end else begin
            y = ins[12] ? ref_mem[m_a[14:0]] : m_a;
            check("exec_op", alu_op, ins[11:6]);
            check("exec_x", alu_x, m_d);
            check("exec_y", alu_y, y);
            res = ref_comp(ins[11:6], m_d, y);
            a_old = m_a;
            jmp = (ins[2] && $signed(res) < 0) || (ins[1] && res == 16'd0) ||
                  (ins[0] && $signed(res) > 0);
            @(posedge clk);
            #1;
            instr_valid = 1'($urandom_range(0, 1));
            check("wb_req", instr_req, 0);
            check("wb_we", mem_we, ins[3]);
            if (ins[3]) begin
                check("wb_addr", mem_addr, a_old[14:0]);
                check("wb_data", mem_wdata, res);
                ref_mem[a_old[14:0]] = res;
            end
            if (ins[5]) m_a = res;
            if (ins[4]) m_d = res;
            m_pc = jmp ? a_old[14:0] : pc_next;
            @(posedge clk);
            #1;
            instr_valid = 1'b0;
            check("post_we", mem_we, 0);
        end
        check("reg_a", dut.a_reg, m_a);
        check("reg_d", dut.d_reg, m_d);
        check("next_req", instr_req, 1);
        check("next_pc", instr_addr, m_pc);
        $display("instr 0x%04h stall=%0d -> pc=0x%04h a=0x%04h d=0x%04h", ins, stall,
                 instr_addr, dut.a_reg, dut.d_reg);
    endtask

    initial begin
        logic [15:0] ins;
        for (int i = 0; i < 32768; i++) begin
            phys_mem[i] = 16'($urandom);
            ref_mem[i] = phys_mem[i];
        end
        do_reset();

        // Load A then copy to D
        run_instr(16'h0005, 0);
        run_instr(16'hEC10, 0);
        check("t2_a", dut.a_reg, 16'd5);
        check("t2_d", dut.d_reg, 16'd5);
        check("t2_pc", instr_addr, 15'd2);

        // M=D+1 with A=5
        run_instr(16'hE7C8, 0);
        check("t3_mem", phys_mem[5], 16'd6);

        // D;JEQ taken with D=0, not taken with D=1
        run_instr(16'hEA90, 0);
        run_instr(16'h0010, 0);
        run_instr(16'hE302, 0);
        check("t4_taken", instr_addr, 15'h0010);
        run_instr(16'hEFD0, 0);
        run_instr(16'h0010, 0);
        run_instr(16'hE302, 1);
        check("t4_fall", instr_addr, 15'h0013);

        // Stall, then PC wrap from 0x7FFF
        run_instr(16'h7FFF, 3);
        run_instr(16'hEA87, 0);
        check("t5_at_top", instr_addr, 15'h7FFF);
        run_instr(16'h1234, 0);
        check("t5_wrap", instr_addr, 15'h0000);

        // Reset during a WB that writes D and M
        do_reset();
        instr_valid = 1'b1;
        instr = 16'hE7D8;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t6_we_before", mem_we, 1);
        rst_n = 1'b0;
        #1;
        check("t6_we_async", mem_we, 0);
        check("t6_req_async", instr_req, 0);
        do_reset();
        check("t6_d", dut.d_reg, 16'd0);
        check("t6_mem", phys_mem[0], ref_mem[0]);

        // Random programs
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                ins = {1'b0, 15'($urandom)};
            end else begin
                ins = {1'b1, 2'($urandom), 1'($urandom),
                       comp_tab[$urandom_range(0, 17)], 3'($urandom), 3'($urandom)};
            end
            run_instr(ins, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
